// File: rtl/button_cond_pkg.sv
// rtl/button_cond_pkg.sv - shared register map, FSM encoding and event field layout for button_cond
package button_cond_pkg;

  localparam logic BTN_EVT_ADDR = 1'b0;
  localparam logic BTN_LVL_ADDR = 1'b1;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_t;

  // Event register is three NBTN-wide fields; firmware locates a field with evt_ofs().
  localparam int EVT_FIELD_PRESS   = 0;
  localparam int EVT_FIELD_LONG    = 1;
  localparam int EVT_FIELD_RELEASE = 2;
  localparam int EVT_FIELDS        = 3;

  function automatic int evt_ofs(input int field, input int nbtn);
    return field * nbtn;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button: 2-flop sync, debounce and press/long FSM; BTN_REPEAT_EN adds auto-repeat
module btn_debounce
  import button_cond_pkg::*;
#(
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_long,
  output logic o_release
);

  localparam int CNT_W = $clog2(max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  btn_state_t       r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic             r_long_done;

  logic             w_sync;
  logic             w_held;
  logic             w_deb_done;
  logic             w_long_stb;
  logic             w_rep_stb;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_hold_inc;

  assign w_sync     = r_sync[1];
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_hold_inc = (r_hold == '1) ? r_hold : r_hold + CNT_W'(1);
  assign w_deb_done = (w_cnt_inc >= DEB_LAST);

  assign o_level    = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_PEND);
  // Hold time accrues only while the debounced press is still seen on the pin.
  assign w_held     = o_level && w_sync;
  assign w_long_stb = w_held && !r_long_done && (w_hold_inc >= LONG_LAST);

  assign o_press    = ((r_state == ST_PRESS_PEND) && w_sync && w_deb_done) || w_rep_stb;
  assign o_long     = w_long_stb;
  assign o_release  = (r_state == ST_RELEASE_PEND) && !w_sync && w_deb_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 2'b00;
      r_state     <= ST_RELEASED;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_long_done <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      case (r_state)
        ST_RELEASED: begin
          if (w_sync) begin
            r_state <= ST_PRESS_PEND;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_PEND: begin
          if (!w_sync) begin
            r_state <= ST_RELEASED;
          end else if (w_deb_done) begin
            r_state     <= ST_PRESSED;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_long_done <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_PEND;
            r_cnt   <= '0;
          end else begin
            r_hold <= w_hold_inc;
            if (w_long_stb) r_long_done <= 1'b1;
          end
        end
        ST_RELEASE_PEND: begin
          if (w_sync) begin
            r_state <= ST_PRESSED;
            r_hold  <= w_hold_inc;
            if (w_long_stb) r_long_done <= 1'b1;
          end else if (w_deb_done) begin
            r_state <= ST_RELEASED;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_RELEASED;
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_PERIOD = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] w_rep_inc;

  assign w_rep_inc = (r_rep == '1) ? r_rep : r_rep + CNT_W'(1);
  assign w_rep_stb = w_held && r_long_done && (w_rep_inc >= REP_PERIOD);

  always_ff @(posedge clk) begin
    if (rst || !w_held || !r_long_done || w_rep_stb) begin
      r_rep <= '0;
    end else begin
      r_rep <= w_rep_inc;
    end
  end
`else
  assign w_rep_stb = 1'b0;
`endif

endmodule

// File: rtl/button_cond.sv
// rtl/button_cond.sv - button conditioner: sticky W1C event flags and level view; BTN_REPEAT_EN enables auto-repeat
module button_cond
  import button_cond_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int NBTN          = 2,
  parameter int DEB_CYCLES    = 1000000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NBTN-1:0]   button,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              event_pending
);

  localparam int EVT_W = EVT_FIELDS * NBTN;

  logic [NBTN-1:0]  w_level;
  logic [NBTN-1:0]  w_press_stb;
  logic [NBTN-1:0]  w_long_stb;
  logic [NBTN-1:0]  w_rel_stb;
  logic [NBTN-1:0]  r_press;
  logic [NBTN-1:0]  r_long;
  logic [NBTN-1:0]  r_rel;
  logic             r_pending;
  logic             w_clr_en;
  logic [EVT_W-1:0] w_clr;
  logic [EVT_W-1:0] w_evt;
  logic             w_unused_din;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .i_btn     (button[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press_stb[g]),
      .o_long    (w_long_stb[g]),
      .o_release (w_rel_stb[g])
    );
  end

  assign w_clr_en = sel && we && (addr == BTN_EVT_ADDR);
  assign w_clr    = w_clr_en ? data_in[EVT_W-1:0] : '0;
  assign w_evt    = {r_rel, r_long, r_press};

  // A strobe in the same cycle as a clear of that bit wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press   <= '0;
      r_long    <= '0;
      r_rel     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_press   <= (r_press & ~w_clr[evt_ofs(EVT_FIELD_PRESS, NBTN) +: NBTN]) | w_press_stb;
      r_long    <= (r_long  & ~w_clr[evt_ofs(EVT_FIELD_LONG, NBTN) +: NBTN])  | w_long_stb;
      r_rel     <= (r_rel   & ~w_clr[evt_ofs(EVT_FIELD_RELEASE, NBTN) +: NBTN]) | w_rel_stb;
      r_pending <= |w_evt;
    end
  end

  assign event_pending = r_pending;
  assign data_out      = !sel ? '0 :
                         (addr == BTN_LVL_ADDR) ? DATA_W'(w_level) : DATA_W'(w_evt);

  assign w_unused_din  = ^data_in[DATA_W-1:EVT_W];

endmodule

// File: tb/tb_button_cond.sv
// tb/tb_button_cond.sv - randomized scoreboard bench for button_cond against a behavioural model
module tb_button_cond;

  localparam int DATA_W = 32;
  localparam int NBTN   = 2;
  localparam int DEB    = 4;
  localparam int LONG   = 20;
  localparam int REP    = 8;
  localparam int EVT_W  = 3 * NBTN;

  logic              clk = 1'b0;
  logic              rst;
  logic [NBTN-1:0]   button;
  logic              sel;
  logic              we;
  logic              addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              event_pending;

  button_cond #(
    .DATA_W        (DATA_W),
    .NBTN          (NBTN),
    .DEB_CYCLES    (DEB),
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .button        (button),
    .sel           (sel),
    .we            (we),
    .addr          (addr),
    .data_in       (data_in),
    .data_out      (data_out),
    .event_pending (event_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              pend;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Model: pin delayed two cycles, a debounced level, and run/hold/repeat cycle counts.
  bit [NBTN-1:0]  m_s1, m_s2, m_level, m_long_done;
  int             m_run[NBTN];
  int             m_hold[NBTN];
  int             m_rep[NBTN];
  bit [EVT_W-1:0] m_flags;
  bit             m_pend;

  task automatic model_step(input logic [NBTN-1:0] btn, input logic r, input logic s,
                            input logic w, input logic a, input logic [DATA_W-1:0] d);
    bit [EVT_W-1:0] set_v;
    bit [EVT_W-1:0] clr_v;
    bit             sb;
    bit             held;
    set_v = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_long_done = '0;
      m_flags = '0; m_pend = 1'b0;
      for (int b = 0; b < NBTN; b++) begin
        m_run[b] = 0; m_hold[b] = 0; m_rep[b] = 0;
      end
      return;
    end
    for (int b = 0; b < NBTN; b++) begin
      sb   = m_s2[b];
      held = m_level[b] && sb;
      if (sb != m_level[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_run[b]   = 0;
          m_level[b] = sb;
          if (sb) begin
            set_v[b]        = 1'b1;
            m_hold[b]       = 0;
            m_long_done[b]  = 1'b0;
          end else begin
            set_v[2*NBTN+b] = 1'b1;
          end
        end
      end else begin
        m_run[b] = 0;
      end
      if (held) begin
        m_hold[b]++;
        if (m_long_done[b]) begin
`ifdef BTN_REPEAT_EN
          m_rep[b]++;
          if (m_rep[b] == REP) begin
            set_v[b] = 1'b1;
            m_rep[b] = 0;
          end
`endif
        end else begin
          m_rep[b] = 0;
          if (m_hold[b] >= LONG - 1) begin
            set_v[NBTN+b]  = 1'b1;
            m_long_done[b] = 1'b1;
          end
        end
      end else begin
        m_rep[b] = 0;
      end
    end
    m_s2    = m_s1;
    m_s1    = btn;
    clr_v   = (s && w && !a) ? d[EVT_W-1:0] : '0;
    m_pend  = |m_flags;
    m_flags = (m_flags & ~clr_v) | set_v;
  endtask

  task automatic cyc(input logic [NBTN-1:0] btn, input logic r, input logic s,
                     input logic w, input logic a, input logic [DATA_W-1:0] d);
    exp_t e;
    button  = btn;
    rst     = r;
    sel     = s;
    we      = w;
    addr    = a;
    data_in = d;
    if (s) begin
      e.data = a ? DATA_W'(m_level) : DATA_W'(m_flags);
      e.pend = m_pend;
      exp_q.push_back(e);
    end
    model_step(btn, r, s, w, a, d);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [NBTN-1:0] btn, input int n);
    for (int i = 0; i < n; i++) cyc(btn, 1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 32'h0);
  endtask

  function automatic int pick_len();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(1, 3));
      1:       return int'($urandom_range(4, 6));
      2:       return int'($urandom_range(7, 15));
      default: return int'($urandom_range(20, 45));
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (sel === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: read seen, expected queue empty");
        end else begin
          mon_e = exp_q.pop_front();
          checks++;
          if (data_out !== mon_e.data) begin
            errors++;
            $display("FAIL data_out addr=%0d t=%0t: got %h expected %h", addr, $time, data_out, mon_e.data);
          end
          checks++;
          if (event_pending !== mon_e.pend) begin
            errors++;
            $display("FAIL event_pending t=%0t: got %b expected %b", $time, event_pending, mon_e.pend);
          end
        end
      end
    end
  end

  initial begin
    logic [NBTN-1:0] lvl;
    int              rem[NBTN];
    logic            s, w, a, r;

    cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    rd(2'b00, 5);

    rd(2'b01, 10);
    rd(2'b00, 12);
    cyc(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3F);

    rd(2'b10, 3);
    rd(2'b00, 10);

    rd(2'b01, 30);
    for (int i = 0; i < 10; i++) cyc(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10);
    rd(2'b00, 4);
    cyc(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h05);
    rd(2'b00, 3);
    cyc(2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F);
    rd(2'b00, 2);

    rd(2'b01, 15);
    cyc(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    rd(2'b01, 15);
    rd(2'b00, 10);
    cyc(2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3F);

    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) cyc(2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h01);
      else            cyc(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    rd(2'b00, 10);

    lvl = '0;
    for (int b = 0; b < NBTN; b++) rem[b] = pick_len();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NBTN; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          rem[b] = pick_len();
        end
        rem[b]--;
      end
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 3) != 0);
      w = s && ($urandom_range(0, 5) == 0);
      a = 1'($urandom_range(0, 1));
      cyc(lvl, r, s, w, a, $urandom());
    end

    rd(2'b00, 8);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
